// File: rtl/dijkstra_pkg.sv
// Shared widths, sentinel values and controller state encoding for the pathfinding datapath.
package dijkstra_pkg;

    localparam int unsigned NODE_ID_W = 9;
    localparam int unsigned DIST_W    = 14;

    localparam logic [DIST_W-1:0]    DIST_INF  = 14'h3FFF;
    localparam logic [NODE_ID_W-1:0] NODE_NONE = 9'h1FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TINIT,
        S_SINIT,
        S_LOOP,
        S_DONE,
        S_ERROR
    } ctrl_state_t;

endpackage

// File: rtl/dijkstra_result_store.sv
// Snapshot of the last completed distance/predecessor arrays with a registered query port.
module dijkstra_result_store
    import dijkstra_pkg::*;
#(
    parameter int unsigned MAX_NODES = 15
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 capture_i,
    input  logic [MAX_NODES-1:0][DIST_W-1:0]     distance_i,
    input  logic [MAX_NODES-1:0][NODE_ID_W-1:0]  neighbour_i,
    input  logic                                 query_valid_i,
    input  logic [NODE_ID_W-1:0]                 query_node_i,
    output logic                                 query_ready_o,
    output logic [DIST_W-1:0]                    query_distance_o,
    output logic [NODE_ID_W-1:0]                 query_neighbour_o
);

    localparam int unsigned IdxW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    logic [MAX_NODES-1:0][DIST_W-1:0]    dist_q;
    logic [MAX_NODES-1:0][NODE_ID_W-1:0] nbr_q;
    logic                                ready_q;
    logic [DIST_W-1:0]                   qdist_q, qdist_d;
    logic [NODE_ID_W-1:0]                qnbr_q, qnbr_d;
    logic [IdxW-1:0]                     idx;

    always_comb begin
        idx    = query_node_i[IdxW-1:0];
        qdist_d = qdist_q;
        qnbr_d  = qnbr_q;
        if (query_valid_i) begin
            if (query_node_i < NODE_ID_W'(MAX_NODES)) begin
                qdist_d = dist_q[idx];
                qnbr_d  = nbr_q[idx];
            end else begin
                qdist_d = DIST_INF;
                qnbr_d  = NODE_NONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dist_q  <= '0;
            nbr_q   <= '0;
            ready_q <= 1'b0;
            qdist_q <= '0;
            qnbr_q  <= '0;
        end else begin
            if (capture_i) begin
                dist_q <= distance_i;
                nbr_q  <= neighbour_i;
            end
            ready_q <= query_valid_i;
            qdist_q <= qdist_d;
            qnbr_q  <= qnbr_d;
        end
    end

    assign query_ready_o     = ready_q;
    assign query_distance_o  = qdist_q;
    assign query_neighbour_o = qnbr_q;

endmodule

// File: rtl/dijkstra_controller.sv
// Top-level sequencer: table init, search init and relaxation loop with a per-stage watchdog,
// table read-address mux and a result snapshot served to host queries.
module dijkstra_controller
    import dijkstra_pkg::*;
#(
    parameter int unsigned MAX_NODES      = 15,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req,
    input  logic [NODE_ID_W-1:0]                 req_start_id,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    input  logic                                 abort,
    output logic [NODE_ID_W-1:0]                 start_id,
    output logic                                 tinit_start,
    output logic                                 sinit_start,
    output logic                                 loop_start,
    input  logic                                 tinit_finished,
    input  logic                                 sinit_finished,
    input  logic                                 loop_finished,
    output logic                                 sinit_in_progress,
    input  logic [MAX_NODES-1:0][NODE_ID_W-1:0]  sinit_read_address,
    input  logic [MAX_NODES-1:0][NODE_ID_W-1:0]  loop_read_address,
    output logic [MAX_NODES-1:0][NODE_ID_W-1:0]  table_read_address,
    input  logic [MAX_NODES-1:0][DIST_W-1:0]     distance_out,
    input  logic [MAX_NODES-1:0][NODE_ID_W-1:0]  neighbour_out,
    input  logic                                 query_valid,
    input  logic [NODE_ID_W-1:0]                 query_node,
    output logic                                 query_ready,
    output logic [DIST_W-1:0]                    query_distance,
    output logic [NODE_ID_W-1:0]                 query_neighbour,
    output logic                                 result_valid
);

    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

    ctrl_state_t          state_q, state_d;
    logic                 first_q, first_d;
    logic [15:0]          wd_q, wd_d;
    logic [NODE_ID_W-1:0] start_id_q, start_id_d;
    logic                 error_q, error_d;
    logic                 valid_q, valid_d;
    logic                 capture;
    logic                 stage_fin;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            wd_q       <= '0;
            start_id_q <= '0;
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            wd_q       <= wd_d;
            start_id_q <= start_id_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        wd_d       = '0;
        start_id_d = start_id_q;
        error_d    = error_q;
        valid_d    = valid_q;
        capture    = 1'b0;
        unique case (state_q)
            S_TINIT: stage_fin = tinit_finished;
            S_SINIT: stage_fin = sinit_finished;
            S_LOOP:  stage_fin = loop_finished;
            default: stage_fin = 1'b0;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    start_id_d = req_start_id;
                    error_d    = 1'b0;
                    valid_d    = 1'b0;
                    first_d    = 1'b1;
                    state_d    = S_TINIT;
                end
            end
            S_TINIT, S_SINIT, S_LOOP: begin
                wd_d = wd_q + 16'd1;
                if (abort) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                // a finished level seen during the start pulse is left over from the last run
                end else if (stage_fin && !first_q) begin
                    wd_d = '0;
                    if (state_q == S_LOOP) begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        first_d = 1'b1;
                        state_d = (state_q == S_TINIT) ? S_SINIT : S_LOOP;
                    end
                end else if (wd_q == WdLimit) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    assign busy              = (state_q == S_TINIT) || (state_q == S_SINIT) || (state_q == S_LOOP);
    assign done              = (state_q == S_DONE);
    assign error             = error_q;
    assign result_valid      = valid_q;
    assign start_id          = start_id_q;
    assign tinit_start       = (state_q == S_TINIT) && first_q;
    assign sinit_start       = (state_q == S_SINIT) && first_q;
    assign loop_start        = (state_q == S_LOOP) && first_q;
    assign sinit_in_progress = (state_q == S_SINIT);
    assign table_read_address = (state_q == S_SINIT) ? sinit_read_address : loop_read_address;

    dijkstra_result_store #(
        .MAX_NODES (MAX_NODES)
    ) u_store (
        .clk_i             (clk),
        .rst_ni            (reset),
        .capture_i         (capture),
        .distance_i        (distance_out),
        .neighbour_i       (neighbour_out),
        .query_valid_i     (query_valid),
        .query_node_i      (query_node),
        .query_ready_o     (query_ready),
        .query_distance_o  (query_distance),
        .query_neighbour_o (query_neighbour)
    );

endmodule

// File: tb/tb_dijkstra_controller.sv
// Scoreboard bench: stub stages with known delays, expected run outcomes and query answers queued
// at issue time and checked by an independent monitor.
module tb_dijkstra_controller;
    import dijkstra_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          reset, req, abort, query_valid;
    logic [8:0]                    req_start_id, query_node, start_id, query_neighbour;
    logic                          busy, done, error, result_valid, query_ready;
    logic                          tinit_start, sinit_start, loop_start, sinit_in_progress;
    logic                          tinit_finished = 1'b0, sinit_finished = 1'b0;
    logic                          loop_finished = 1'b0;
    logic [N-1:0][8:0]             sinit_read_address, loop_read_address, table_read_address;
    logic [N-1:0][13:0]            distance_out;
    logic [N-1:0][8:0]             neighbour_out;
    logic [13:0]                   query_distance;

    dijkstra_controller #(
        .MAX_NODES      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req                (req),
        .req_start_id       (req_start_id),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .abort              (abort),
        .start_id           (start_id),
        .tinit_start        (tinit_start),
        .sinit_start        (sinit_start),
        .loop_start         (loop_start),
        .tinit_finished     (tinit_finished),
        .sinit_finished     (sinit_finished),
        .loop_finished      (loop_finished),
        .sinit_in_progress  (sinit_in_progress),
        .sinit_read_address (sinit_read_address),
        .loop_read_address  (loop_read_address),
        .table_read_address (table_read_address),
        .distance_out       (distance_out),
        .neighbour_out      (neighbour_out),
        .query_valid        (query_valid),
        .query_node         (query_node),
        .query_ready        (query_ready),
        .query_distance     (query_distance),
        .query_neighbour    (query_neighbour),
        .result_valid       (result_valid)
    );

    // Stage stubs: finished rises d cycles after the start pulse and is held as a level
    int d_tinit = 5, d_sinit = 7, d_loop = 20;
    bit loop_hang = 1'b0;
    int cnt_t = 0, cnt_s = 0, cnt_l = 0;

    always @(posedge clk) begin
        if (tinit_start) begin
            cnt_t <= 1; tinit_finished <= 1'b0;
        end else if (cnt_t != 0) begin
            if (cnt_t == d_tinit - 1) begin tinit_finished <= 1'b1; cnt_t <= 0; end
            else cnt_t <= cnt_t + 1;
        end
        if (sinit_start) begin
            cnt_s <= 1; sinit_finished <= 1'b0;
        end else if (cnt_s != 0) begin
            if (cnt_s == d_sinit - 1) begin sinit_finished <= 1'b1; cnt_s <= 0; end
            else cnt_s <= cnt_s + 1;
        end
        if (loop_start) begin
            cnt_l <= 1; loop_finished <= 1'b0;
        end else if (cnt_l != 0) begin
            if (cnt_l == d_loop - 1) begin loop_finished <= !loop_hang; cnt_l <= 0; end
            else cnt_l <= cnt_l + 1;
        end
    end

    typedef struct {
        int         kind;        // 0 done, 1 error
        logic [8:0] sid;
        int         seq;         // start pulses seen, base-4 digits 1/2/3
        int         busy_cycles; // checked for completed runs only
        int         err_lat;     // cycles loop_start -> error, -1 if not checked
    } outcome_t;
    typedef struct {
        logic [13:0] d;
        logic [8:0]  n;
    } qexp_t;

    outcome_t run_q[$];
    qexp_t    qry_q[$];
    int       n_checks = 0, n_err = 0;
    bit       mon_en = 1'b0;
    logic [13:0] ref_dist[N];
    logic [8:0]  ref_nbr[N];
    logic [13:0] drv_dist[N];
    logic [8:0]  drv_nbr[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents done, a new error or query_ready
    int cyc = 0, busy_cnt = 0, pulse_seq = 0, loop_start_cyc = 0, mux_bad = 0;
    bit prev_busy = 1'b0, prev_error = 1'b0, in_sinit = 1'b0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            outcome_t o;
            qexp_t    q;
            if (busy && !prev_busy) begin busy_cnt = 0; pulse_seq = 0; end
            if (busy) busy_cnt++;
            if (tinit_start) pulse_seq = pulse_seq * 4 + 1;
            if (sinit_start) begin pulse_seq = pulse_seq * 4 + 2; in_sinit = 1'b1; end
            if (loop_start) begin pulse_seq = pulse_seq * 4 + 3; loop_start_cyc = cyc; end
            if (loop_start || !busy) in_sinit = 1'b0;
            if (table_read_address !== (in_sinit ? sinit_read_address : loop_read_address) ||
                sinit_in_progress !== in_sinit) mux_bad++;
            if (done) begin
                if (run_q.size() == 0) check("done_unexpected", run_q.size(), 1);
                else begin
                    o = run_q.pop_front();
                    check("done_kind", 0, o.kind);
                    check("done_start_id", start_id, o.sid);
                    check("done_pulse_order", pulse_seq, o.seq);
                    check("done_busy_cycles", busy_cnt, o.busy_cycles);
                    check("done_result_valid", result_valid, 1);
                    check("done_busy_low", busy, 0);
                end
            end
            if (error === 1'b1 && !prev_error) begin
                if (run_q.size() == 0) check("error_unexpected", run_q.size(), 1);
                else begin
                    o = run_q.pop_front();
                    check("error_kind", 1, o.kind);
                    check("error_pulse_order", pulse_seq, o.seq);
                    if (o.err_lat >= 0) check("timeout_latency", cyc - loop_start_cyc, o.err_lat);
                    check("error_busy_low", busy, 0);
                    check("error_result_valid", result_valid, 0);
                end
            end
            if (query_ready) begin
                if (qry_q.size() == 0) check("query_unexpected", qry_q.size(), 1);
                else begin
                    q = qry_q.pop_front();
                    check("query_distance", query_distance, q.d);
                    check("query_neighbour", query_neighbour, q.n);
                end
            end
            prev_busy  = busy;
            prev_error = (error === 1'b1);
        end
    end

    task automatic issue_query(input logic [8:0] node);
        qexp_t e;
        if (node < N) begin e.d = ref_dist[node]; e.n = ref_nbr[node]; end
        else begin e.d = 14'h3FFF; e.n = 9'h1FF; end
        qry_q.push_back(e);
        query_valid = 1'b1;
        query_node  = node;
        @(negedge clk);
        query_valid = 1'b0;
    endtask

    task automatic drive_data(input bit fixed);
        for (int i = 0; i < N; i++) begin
            drv_dist[i] = 14'($urandom_range(0, 16383));
            drv_nbr[i]  = 9'($urandom_range(0, 511));
            sinit_read_address[i] = fixed ? 9'd5 : 9'($urandom_range(0, 511));
            loop_read_address[i]  = fixed ? 9'd9 : 9'($urandom_range(0, 511));
        end
        if (fixed) begin drv_dist[3] = 14'd37; drv_nbr[3] = 9'd1; end
        for (int i = 0; i < N; i++) begin
            distance_out[i]  = drv_dist[i];
            neighbour_out[i] = drv_nbr[i];
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        if (busy) check("run_bound", busy, 0);
    endtask

    // mode 0: completes, 1: loop hangs until watchdog, 2: abort together with sinit_finished
    task automatic do_run(input logic [8:0] id, input int dt, input int ds, input int dl,
                          input int mode, input bit fixed);
        outcome_t o;
        int       i;
        d_tinit = dt; d_sinit = ds; d_loop = dl; loop_hang = (mode == 1);
        drive_data(fixed);
        o.kind = (mode == 0) ? 0 : 1;
        o.sid  = id;
        o.seq  = (mode == 2) ? 6 : 27;
        o.busy_cycles = (dt + 1) + (ds + 1) + (dl + 1);
        o.err_lat     = (mode == 1) ? TO : -1;
        run_q.push_back(o);
        req = 1'b1; req_start_id = id;
        @(negedge clk);
        req = 1'b0; req_start_id = 9'($urandom_range(0, 511));
        check("accept_busy", busy, 1);
        check("accept_start_id", start_id, id);
        check("accept_error_cleared", error, 0);
        if (mode == 0) issue_query(9'($urandom_range(0, 5)));
        if (mode == 2) begin
            for (i = 0; i < 500 && !(sinit_in_progress && sinit_finished && !sinit_start); i++)
                @(negedge clk);
            if (i == 500) check("abort_window_bound", sinit_finished, 1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        wait_idle();
        if (mode == 0) begin
            for (int k = 0; k < N; k++) begin ref_dist[k] = drv_dist[k]; ref_nbr[k] = drv_nbr[k]; end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int m;
        reset = 1'b0; req = 1'b0; abort = 1'b0; query_valid = 1'b0;
        req_start_id = 9'd0; query_node = 9'd0;
        sinit_read_address = '0; loop_read_address = '0;
        distance_out = '0; neighbour_out = '0;
        for (int k = 0; k < N; k++) begin ref_dist[k] = '0; ref_nbr[k] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, error, tinit_start, sinit_start, loop_start,
              sinit_in_progress, result_valid, query_ready, start_id, query_distance,
              query_neighbour}, 64'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        issue_query(9'd2);

        // directed run: id 2, stubs 5/7/20, node 3 holds 37 via 1
        do_run(9'd2, 5, 7, 20, 0, 1'b1);
        check("result_valid_after_done", result_valid, 1);
        issue_query(9'd3);
        issue_query(9'd9);

        // loop never finishes: watchdog aborts, snapshot kept
        do_run(9'($urandom_range(0, 511)), 4, 6, 10, 1, 1'b0);
        check("timeout_error_sticky", error, 1);
        check("timeout_result_valid", result_valid, 0);
        issue_query(9'd3);

        // abort with sinit_finished in the same cycle, then a clean run
        do_run(9'($urandom_range(0, 511)), 3, 8, 10, 2, 1'b1);
        check("abort_error_sticky", error, 1);
        do_run(9'($urandom_range(0, 511)), 6, 3, 9, 0, 1'b1);
        check("rerun_error_clear", error, 0);
        issue_query(9'd1);

        // one-cycle reset during the loop stage
        d_tinit = 4; d_sinit = 4; d_loop = 20; loop_hang = 1'b0;
        drive_data(1'b0);
        req = 1'b1; req_start_id = 9'd77;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 200 && !loop_start; i++) @(negedge clk);
        check("reset_test_loop_reached", loop_start, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", {busy, done, error, tinit_start, sinit_start, loop_start,
              sinit_in_progress, result_valid, query_ready, start_id, query_distance,
              query_neighbour}, 64'd0);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin ref_dist[k] = '0; ref_nbr[k] = '0; end
        repeat (30) @(negedge clk);
        check("stale_loop_finished_ignored", busy, 0);
        issue_query(9'd3);
        do_run(9'd300, 5, 5, 5, 0, 1'b0);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 4);
            do_run(9'($urandom_range(0, 511)), $urandom_range(2, 20), $urandom_range(2, 20),
                   $urandom_range(2, 20), (m < 3) ? 0 : m - 2, 1'b0);
            issue_query(9'($urandom_range(0, 3)));
            issue_query(9'($urandom_range(0, 511)));
        end

        repeat (3) @(negedge clk);
        check("mux_bad_cycles", mux_bad, 0);
        check("pending_outcomes", run_q.size(), 0);
        check("pending_queries", qry_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dijkstra_controller.md
Name: dijkstra_controller

Overview:
- Top-level sequencer for the pathfinding datapath: table initialisation, search initialisation, then the main relaxation loop.
- Accepts a route request with a start node and pulses each stage's start in order. Owns the shared table read-address mux and enforces a per-stage watchdog.
- Snapshots the final distance/neighbour arrays and serves single-node queries to the host-side logic.

Parameters:
MAX_NODES, 15, number of graph nodes / table ports
TIMEOUT_CYCLES, 65535, max cycles any one stage may run before abort (must fit 16 bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  1  route request strobe (sampled only in IDLE)
req_start_id  in  9  start node for request
busy  out  1  high from accept until DONE/ERROR
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until next accepted req; stage timeout or abort
abort  in  1  cancel in-flight search
start_id  out  9  latched req_start_id, stable while busy
tinit_start / sinit_start / loop_start  out  1 each  one-cycle stage start pulses
tinit_finished / sinit_finished / loop_finished  in  1 each  stage completion
sinit_in_progress  out  1  high in S_SINIT (drives init in_progress)
sinit_read_address  in  [MAX_NODES][9]  search-init table addresses
loop_read_address  in  [MAX_NODES][9]  loop table addresses
table_read_address  out  [MAX_NODES][9]  muxed table addresses
distance_out  in  [MAX_NODES][14]  loop result distances
neighbour_out  in  [MAX_NODES][9]  loop result predecessors
query_valid  in  1  query strobe
query_node  in  9  node to read
query_ready  out  1  one cycle after an accepted query
query_distance  out  14  snapshot distance
query_neighbour  out  9  snapshot predecessor
result_valid  out  1  snapshot holds a complete result

Behaviour:
- Reset (reset==0 at clk edge): state S_IDLE. All outputs 0, start_id=0, snapshot arrays cleared to 0, watchdog=0.
- FSM: S_IDLE -> S_TINIT -> S_SINIT -> S_LOOP -> S_DONE -> S_IDLE; any running state -> S_ERROR -> S_IDLE.
- S_IDLE, req=1: latch start_id, clear error and result_valid, busy=1, go to S_TINIT. tinit_start pulses high in the first cycle in S_TINIT.
- Each running state: its start output is high exactly the first cycle after entry; watchdog is cleared on entry and increments each cycle. Its finished input, when seen at least 1 cycle after the start pulse, moves to the next state and pulses that stage's start.
- A finished asserted in the same cycle as its own start pulse is ignored (stale level from the previous run).
- S_LOOP + loop_finished: copy distance_out/neighbour_out into the snapshot on that edge, go to S_DONE.
- S_DONE, one cycle: done=1, result_valid=1, busy=0, then S_IDLE.
- Timeout: watchdog reaching TIMEOUT_CYCLES-1 without finished -> S_ERROR.
- abort=1 in any running state -> S_ERROR. abort has priority over finished in the same cycle.
- S_ERROR, one cycle: error=1 (sticky), busy=0, result_valid stays 0, then S_IDLE. Start outputs are never asserted outside the pulse rule.
- req while busy: ignored, no queuing.
- Read mux is combinational: table_read_address = sinit_read_address when state==S_SINIT, otherwise loop_read_address. sinit_in_progress = (state==S_SINIT).
- Query: accepted in any state. Registered, 1-cycle latency.
  - query_node < MAX_NODES: outputs snapshot[query_node].
  - query_node >= MAX_NODES: outputs distance 14'h3FFF, neighbour 9'h1FF.
- The snapshot is unchanged by queries and updated only on loop_finished. Queries during a search return the previous result (result_valid=0 tells the host it is stale).
- Reset mid-operation aborts silently: no done, no error.

Decomposition:
- Package dijkstra_pkg: NODE_ID_W=9, DIST_W=14, DIST_INF=14'h3FFF, NODE_NONE=9'h1FF, and enum ctrl_state_t {S_IDLE,S_TINIT,S_SINIT,S_LOOP,S_DONE,S_ERROR}.
- One sub-module: dijkstra_result_store (snapshot register file plus registered query port).

Test Plan:
- MAX_NODES=4, stub stages finish 5/7/20 cycles after start; req with id 2 -> pulses in order, start_id=2, done exactly once, result_valid=1, busy cycle count matches the stub delays.
- After that run, query_node=3 with distance_out[3]=14'd37, neighbour_out[3]=9'd1 at loop_finished -> next cycle query_distance=37, query_neighbour=1. query_node=9 -> 3FFF/1FF.
- Loop stub never finishes, TIMEOUT_CYCLES=50 -> error=1 exactly 50 cycles after loop_start, busy=0, no done, snapshot unchanged.
- abort in S_SINIT asserted together with sinit_finished -> S_ERROR, loop_start never pulses. Next req clears error and completes normally.
- In S_SINIT, sinit addresses=5 and loop addresses=9 -> table_read_address=5. In all other states -> 9.
- reset=0 for one cycle during S_LOOP -> all outputs 0 next cycle. A later loop_finished is ignored; the next req runs cleanly.
